// File: rtl/dir_rom_scan_ctrl.sv
// Direction-bin ROM sweep sequencer: walks one bank of the bin ROM
// and streams registered {address, bin} beats over valid/ready.
module dir_rom_scan_ctrl #(
    parameter int ADDR_W = 8,
    parameter int BIN_W  = 5,
    parameter int SEL_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  ori_in,
    input  logic              abort,
    output logic [SEL_W-1:0]  rom_sel,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [BIN_W-1:0]  rom_spo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              load;
    logic              cnt_at_max;

    assign rom_a      = cnt;
    assign busy       = (state == SCAN) || (state == DRAIN);
    assign cnt_at_max = (cnt == CNT_MAX);
    // Output register is free when empty or being drained this cycle.
    assign load       = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rom_sel   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_bin   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            rom_sel <= ori_in;
                            cnt     <= '0;
                            state   <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (load) begin
                            out_addr  <= cnt;
                            out_bin   <= rom_spo;
                            out_valid <= 1'b1;
                            out_last  <= cnt_at_max;
                            // Counter parks at max so no address repeats.
                            if (cnt_at_max) begin
                                state <= DRAIN;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dir_rom_scan_ctrl.sv
// Directed bench for dir_rom_scan_ctrl with a behavioural bank ROM
// and a per-beat scoreboard of the expected address sequence.
module tb_dir_rom_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] ori_in;
    logic       abort;
    logic [5:0] rom_sel;
    logic [7:0] rom_a;
    logic [4:0] rom_spo;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [4:0] out_bin;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    dir_rom_scan_ctrl #(.ADDR_W(8), .BIN_W(5), .SEL_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ori_in    (ori_in),
        .abort     (abort),
        .rom_sel   (rom_sel),
        .rom_a     (rom_a),
        .rom_spo   (rom_spo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_bin   (out_bin),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [4:0] rom_f(input int sel, input int a);
        int v;
        v = a * 7 + sel * 3 + (a >> 3) + (a >> 5) * 11;
        return 5'(v);
    endfunction

    assign rom_spo = rom_f(int'(rom_sel), int'(rom_a));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sel);
        start  = 1'b1;
        ori_in = 6'(sel);
        step();
        start  = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rom_a", rom_a, 0);
        chk("start_rom_sel", rom_sel, sel);
        chk("start_valid", out_valid, 0);
    endtask

    task automatic sweep(input int sel, input bit rnd,
                         input int inj_at, input int abort_at);
        int   exp_a = 0;
        int   cyc   = 0;
        int   dones = 0;
        bit   held  = 0;
        bit   injd  = 0;
        bit   rdy;
        logic [7:0] ha;
        logic [4:0] hb;
        while (exp_a < 256 && cyc < 3000) begin
            rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (out_valid && int'(out_addr) == inj_at && !injd) begin
                start  = 1'b1;
                ori_in = 6'd7;
                injd   = 1;
            end
            if (out_valid && int'(out_addr) == abort_at) begin
                out_ready = 1'b0;
                abort     = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_rom_a", rom_a, 0);
                chk("abort_last", out_last, 0);
                return;
            end
            out_ready = rdy;
            if (held && out_valid) begin
                chk("hold_addr", out_addr, ha);
                chk("hold_bin", out_bin, hb);
            end
            held = 0;
            if (out_valid && rdy) begin
                chk("beat_addr", out_addr, exp_a);
                chk("beat_bin", out_bin, rom_f(sel, exp_a));
                chk("beat_last", out_last, (exp_a == 255) ? 1 : 0);
                exp_a++;
            end else if (out_valid) begin
                held = 1;
                ha   = out_addr;
                hb   = out_bin;
            end
            step();
            cyc++;
            if (done) dones++;
        end
        start = 1'b0;
        chk("beats_all", exp_a, 256);
        chk("done_now", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", out_valid, 0);
        chk("done_count", dones, 1);
        if (!rnd) chk("sweep_len", cyc, 257);
        chk("rom_sel_kept", rom_sel, sel);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ori_in    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_sel", rom_sel, 0);
        chk("rst_rom_a", rom_a, 0);
        chk("rst_addr", out_addr, 0);
        rst = 1'b0;
        step();

        // Full sweep, ready high, stray start at beat 50 ignored.
        out_ready = 1'b1;
        do_start(29);
        sweep(29, 0, 50, -1);
        step();
        chk("done_one_cycle", done, 0);

        // Abort with backpressure at beat 100.
        do_start(29);
        sweep(29, 0, -1, 100);
        step();
        chk("post_abort_done", done, 0);
        chk("post_abort_busy", busy, 0);

        // start and abort together in IDLE.
        start  = 1'b1;
        abort  = 1'b1;
        ori_in = 6'd9;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_sel", rom_sel, 29);

        // Sweep bank 3, then start again in the done cycle.
        out_ready = 1'b1;
        do_start(3);
        sweep(3, 0, -1, -1);
        do_start(11);
        sweep(11, 1, -1, -1);
        step();

        // Async reset while holding in DRAIN.
        out_ready = 1'b1;
        do_start(29);
        repeat (256) step();
        chk("drain_last_addr", out_addr, 255);
        out_ready = 1'b0;
        step();
        chk("drain_hold_valid", out_valid, 1);
        chk("drain_hold_last", out_last, 1);
        chk("drain_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rom_sel", rom_sel, 0);
        chk("arst_rom_a", rom_a, 0);
        chk("arst_addr", out_addr, 0);
        chk("arst_bin", out_bin, 0);
        chk("arst_done", done, 0);
        #3;
        rst = 1'b0;
        step();
        chk("after_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dir_rom_scan_ctrl.md
# dir_rom_scan_ctrl

Sequencer that sweeps a 256-entry direction-bin ROM bank (8-bit address, 5-bit bin) for one keypoint window, streaming `{address, bin}` beats to the descriptor histogram stage over a valid/ready handshake. It sits between the keypoint orientation stage, which supplies the start command and bank select, and the external bank-selected distributed ROM. It owns bank selection, address generation, output registering, backpressure and abort.

## Interface
- `ADDR_W`, 8: ROM address width; window is 2^ADDR_W entries (16x16).
- `BIN_W`, 5: ROM data width (direction bin, 0..31).
- `SEL_W`, 6: ROM bank select width (orientation index).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `ori_in`  in  SEL_W  orientation bank index, sampled with an accepted `start`.
- `abort`  in  1  terminate the current sweep; overrides `start`.
- `rom_sel`  out  SEL_W  bank select to the ROM mux; latched `ori_in`.
- `rom_a`  out  ADDR_W  ROM address, equal to the internal address counter.
- `rom_spo`  in  BIN_W  combinational ROM data for `rom_sel`/`rom_a`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_addr`  out  ADDR_W  address of the current beat.
- `out_bin`  out  BIN_W  bin read at `out_addr`.
- `out_last`  out  1  beat is address 2^ADDR_W-1.
- `busy`  out  1  high in SCAN or DRAIN.
- `done`  out  1  one-cycle pulse after the last beat handshake.

## Operation
- States are IDLE, SCAN and DRAIN.
- Reset values: state IDLE; address counter 0; `rom_sel` 0; `out_valid`, `out_last`, `busy` and `done` all 0; `out_addr` and `out_bin` 0.
- **IDLE:**
  - `start`=1 and `abort`=0: latch `ori_in` into `rom_sel`, clear the counter, go to SCAN.
  - Otherwise remain in IDLE.
- **SCAN:** the output register loads when `out_valid`=0 or `out_ready`=1.
  - On a load: `out_addr`<=counter, `out_bin`<=`rom_spo`, `out_valid`<=1, `out_last`<=(counter==max).
  - After a load with counter<max: counter increments.
  - After a load with counter==max: counter holds, state goes to DRAIN.
  - With `out_valid`=1 and `out_ready`=0: all output registers and the counter hold. The handshake never drops or duplicates a beat.
- **DRAIN:**
  - `out_valid`=1 and `out_ready`=1: `out_valid`<=0, `out_last`<=0, `done`<=1 for one cycle, state goes to IDLE.
  - Otherwise hold.
- **Abort:** `abort`=1 in SCAN or DRAIN. Next edge: state IDLE, `out_valid`=0, `out_last`=0, counter 0, no `done`. A beat presented in the abort cycle counts as not transferred.
- `start` while busy is ignored; it is not queued.
- `start` and `abort` together in IDLE: abort wins and the block stays in IDLE.
- `rom_sel` is stable from the edge after `start` until the next accepted `start`.
- `rom_a` equals the counter in all states.
- The counter never wraps; the beat sequence is exactly 0..max, each address once, in order.
- Reset mid-sweep: immediate return to reset values. The downstream discards any partial window.

## Timing
- Edge E0 samples `start`. After E0: `busy`=1 and `rom_a`=0.
- With `out_ready` held high:
  - Edge E(k+1) loads beat k. First `out_valid` appears after E1.
  - The last beat (255) loads at E256.
  - Its handshake completes at E257. `done`=1 and `busy`=0 in the cycle after E257.
- Sweep length is 257 cycles plus the number of cycles `out_ready` is held low with `out_valid`=1.
- Throughput is one beat per cycle. ROM read is combinational and output is registered, so latency from `rom_a` to `out_bin` is one cycle.
- A new `start` is accepted in the same cycle `done` is high.

## Test plan
- Reset then `start` with `ori_in`=29 and `out_ready`=1.
  - `rom_sel`=29.
  - 256 beats, addr 0..255, each `out_bin` equal to the ROM model.
  - `out_last` only on addr 255.
  - `done` after E257.
- Random `out_ready` (50%) over a full sweep.
  - No beat lost or duplicated.
  - `out_addr`/`out_bin` stable while `out_valid`=1 and `out_ready`=0.
  - Exactly one `done`.
- `abort` at beat 100 with `out_ready`=0.
  - Next cycle: `out_valid`=0, `busy`=0, no `done`.
  - A following `start` (`ori_in`=3) sweeps 0..255 with `rom_sel`=3.
- `start` pulsed at beat 50 with `ori_in`=7: ignored, `rom_sel` stays 29.
- `start` and `abort` together in IDLE: `busy` stays 0.
- `start` in the `done` cycle: the second sweep begins back-to-back.
- Async `rst` asserted mid-DRAIN, between clock edges: all outputs go to 0 immediately, with `out_valid`=0 before the next edge.
